display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 100000, clk cycles per digit slot (legal range 2..2^17-1).
REQ-002 SHALL have parameter DEAD, default 16, anode-off cycles at the start of each slot (legal range 0..PRESCALE-1).
REQ-003 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wr_valid  input  1  shadow-write request.
REQ-006 SHALL have port wr_ready  output  1  shadow-write accept.
REQ-007 SHALL have port wr_addr  input  2  digit index 0..3.
REQ-008 SHALL have port wr_data  input  5  [4]=blank, [3:0]=hex value.
REQ-009 SHALL have port commit  input  1  single-cycle request to copy shadow to active at the next frame boundary.
REQ-010 SHALL have port commit_busy  output  1  high while a commit is pending.
REQ-011 SHALL have port segment  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-012 SHALL have port an  output  4  active-low anodes, digit0=an[0].

Function
REQ-013 SHALL keep slot counter cnt counting 0..PRESCALE-1 and wrapping to 0; tick = (cnt==PRESCALE-1).
REQ-014 SHALL advance digit index idx 0->1->2->3->0 on each tick; frame boundary = tick with idx==3.
REQ-015 SHALL register an and segment; each reflects idx/cnt of the previous cycle (1-cycle latency).
REQ-016 SHALL drive an=4'b1111 and segment=7'b1111111 while cnt<DEAD (DEAD=0 disables dead time).
REQ-017 SHALL otherwise drive an low only on bit idx (1110, 1101, 1011, 0111 for idx 0..3).
REQ-018 SHALL, for an active digit with blank=1, drive an=4'b1111 and segment=7'b1111111 for the whole slot.
REQ-019 SHALL, for an active digit with blank=0, drive segment = decode(active hex value of digit idx).
REQ-020 SHALL accept a write when wr_valid && wr_ready, updating shadow[wr_addr] the following cycle; active entries are unaffected by writes.
REQ-021 SHALL hold wr_ready = !pending, where pending is a registered flag.
REQ-022 SHALL set pending on commit when pending==0; commit while pending==1 is ignored.
REQ-023 SHALL treat a write and commit in the same cycle (pending==0) as write accepted and included in the commit.
REQ-024 SHALL, on a frame boundary with pending==1, copy all four shadow entries to active and clear pending in the same edge.
REQ-025 SHALL, for commit asserted in the frame-boundary cycle with pending==0, take effect at the following frame boundary (one full frame later).
REQ-026 SHALL drive commit_busy = pending.
REQ-027 SHALL use the new active values starting with the slot after the boundary (digit 0 of the next frame); no torn frame.

Reset
REQ-028 SHALL, when rst is high at a clock edge, set cnt=0, idx=0, pending=0, and all shadow/active entries to {blank=1, value=0}, and drive an=4'b1111, segment=7'b1111111, wr_ready=1.
REQ-029 SHALL let rst take priority over a write, commit or boundary in the same cycle; pending work is discarded.
REQ-030 SHALL restart scanning at digit 0, cnt=0 on the first cycle after rst deasserts.

Structure
REQ-031 SHALL place in a shared display package: the active-low segment constants for 0..F, SEG_OFF=7'b1111111, AN_OFF=4'b1111, and the digit-entry type {blank, value[3:0]}.
REQ-032 SHALL instantiate one combinational sub-module seg7_decode (hex[3:0] -> segment[6:0], active-low, 0..F).
REQ-033 SHALL use these seg7_decode codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.

Verification (PRESCALE=8, DEAD=2)
REQ-034 SHALL cover reset then idle 64 cycles -> an=1111, segment=1111111 throughout; wr_ready=1, commit_busy=0.
REQ-035 SHALL cover write 1,2,3,4 to digits 0..3 (blank=0), then commit -> commit_busy high until the frame boundary; then per 8-cycle slot: 2 cycles an=1111, then 6 cycles an=1110/seg=1111001, 1101/0100100, 1011/0110000, 0111/0011001.
REQ-036 SHALL cover wr_valid held while commit pending -> wr_ready=0, no shadow change, write accepted in the cycle after the boundary.
REQ-037 SHALL cover commit in the boundary cycle -> display unchanged for one more frame, then updates.
REQ-038 SHALL cover digit 2 written with blank=1 and committed -> an=1111 for all of slot 2, other slots normal.
REQ-039 SHALL cover rst asserted mid-frame with pending=1 -> outputs blank next cycle, pending cleared, scan restarts at digit 0.

Source files
------------

// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed 4-digit seven-segment display.
package display_scan_ctrl_pkg;

   // One display digit: blank suppresses the digit, value is the hex nibble
   typedef struct packed {
      logic       blank;
      logic [3:0] value;
   } digit_t;

   localparam digit_t DIGIT_RESET = '{blank: 1'b1, value: 4'h0};

   // All-off codes for the active-low segment and anode drivers
   localparam logic [6:0] SEG_OFF = 7'b1111111;
   localparam logic [3:0] AN_OFF  = 4'b1111;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b0000011;
   localparam logic [6:0] SEG_C = 7'b1000110;
   localparam logic [6:0] SEG_D = 7'b0100001;
   localparam logic [6:0] SEG_E = 7'b0000110;
   localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/display_scan_ctrl_seg7_decode.sv
// Hex nibble to active-low seven-segment pattern (0..F).
module seg7_decode
   import display_scan_ctrl_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] segment
);

   // Pure lookup from nibble to segment pattern
   always_comb begin
      segment = SEG_OFF;
      case (hex)
         4'h0: segment = SEG_0;
         4'h1: segment = SEG_1;
         4'h2: segment = SEG_2;
         4'h3: segment = SEG_3;
         4'h4: segment = SEG_4;
         4'h5: segment = SEG_5;
         4'h6: segment = SEG_6;
         4'h7: segment = SEG_7;
         4'h8: segment = SEG_8;
         4'h9: segment = SEG_9;
         4'hA: segment = SEG_A;
         4'hB: segment = SEG_B;
         4'hC: segment = SEG_C;
         4'hD: segment = SEG_D;
         4'hE: segment = SEG_E;
         4'hF: segment = SEG_F;
         default: segment = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 4-digit display scanner with shadow/active digit banks.
// Writes land in the shadow bank; a commit copies the whole shadow bank to
// the active bank only at a frame boundary so a frame is never torn.
module display_scan_ctrl
   import display_scan_ctrl_pkg::*;
#(
   parameter int PRESCALE = 100000,
   parameter int DEAD     = 16
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic [1:0] wr_addr,
   input  logic [4:0] wr_data,
   input  logic       commit,
   output logic       commit_busy,
   output logic [6:0] segment,
   output logic [3:0] an
);

   localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic          pending;
   digit_t        shadow [4];
   digit_t        active [4];
   digit_t        cur;
   logic          tick;
   logic          boundary;
   logic          in_dead;
   logic [6:0]    dec_seg;

   assign tick        = (cnt == CNT_LAST);
   assign boundary    = tick && (idx == 2'd3);
   assign cur         = active[idx];
   assign wr_ready    = !pending;
   assign commit_busy = pending;

   generate
      if (DEAD > 0) begin : g_dead
         localparam logic [CW-1:0] DEAD_C = CW'(DEAD);
         assign in_dead = (cnt < DEAD_C);
      end else begin : g_no_dead
         assign in_dead = 1'b0;
      end
   endgenerate

   seg7_decode u_decode (
      .hex     (cur.value),
      .segment (dec_seg)
   );

   // Slot counter and digit index: one digit slot every PRESCALE cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         idx <= 2'd0;
      end else if (tick) begin
         cnt <= '0;
         idx <= idx + 2'd1;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // Shadow writes, commit request tracking and frame-boundary bank copy
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            shadow[i] <= DIGIT_RESET;
            active[i] <= DIGIT_RESET;
         end
      end else begin
         if (wr_valid && !pending) begin
            shadow[wr_addr] <= digit_t'(wr_data);
         end
         if (boundary && pending) begin
            for (int i = 0; i < 4; i++) begin
               active[i] <= shadow[i];
            end
            pending <= 1'b0;
         end else if (commit && !pending) begin
            pending <= 1'b1;
         end
      end
   end

   // Registered anode/segment drive, blanked during dead time or blank digits
   always_ff @(posedge clk) begin
      if (rst) begin
         an      <= AN_OFF;
         segment <= SEG_OFF;
      end else if (in_dead || cur.blank) begin
         an      <= AN_OFF;
         segment <= SEG_OFF;
      end else begin
         an      <= ~(4'b0001 << idx);
         segment <= dec_seg;
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl with PRESCALE=8, DEAD=2.
module tb_display_scan_ctrl;

   localparam int PRESCALE = 8;
   localparam int DEAD     = 2;
   localparam int FRAME    = 4 * PRESCALE;

   logic       clk;
   logic       rst;
   logic       wr_valid;
   logic       wr_ready;
   logic [1:0] wr_addr;
   logic [4:0] wr_data;
   logic       commit;
   logic       commit_busy;
   logic [6:0] segment;
   logic [3:0] an;

   int total = 0;
   int bad   = 0;
   logic check_on = 1'b0;

   display_scan_ctrl #(.PRESCALE(PRESCALE), .DEAD(DEAD)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .commit      (commit),
      .commit_busy (commit_busy),
      .segment     (segment),
      .an          (an)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference segment table
   function automatic logic [6:0] ref_seg(input logic [3:0] h);
      logic [6:0] t [16];
      t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      return t[h];
   endfunction

   // Model state: time since reset plus the two digit banks
   int         m_pos;
   logic       m_pending;
   logic [4:0] m_shadow [4];
   logic [4:0] m_active [4];
   logic [3:0] m_an;
   logic [6:0] m_seg;

   // Behavioural model: slot position is plain arithmetic on elapsed cycles
   always @(posedge clk) begin
      int slot;
      int phase;
      slot  = (m_pos / PRESCALE) % 4;
      phase = m_pos % PRESCALE;
      if (rst) begin
         m_pos     <= 0;
         m_pending <= 1'b0;
         m_an      <= 4'b1111;
         m_seg     <= 7'b1111111;
         for (int i = 0; i < 4; i++) begin
            m_shadow[i] <= 5'h10;
            m_active[i] <= 5'h10;
         end
      end else begin
         if (phase < DEAD || m_active[slot][4]) begin
            m_an  <= 4'b1111;
            m_seg <= 7'b1111111;
         end else begin
            m_an  <= 4'b1111 ^ (4'b0001 << slot);
            m_seg <= ref_seg(m_active[slot][3:0]);
         end
         m_pos <= m_pos + 1;
         if (wr_valid && !m_pending) m_shadow[wr_addr] <= wr_data;
         if ((m_pos % FRAME) == FRAME - 1 && m_pending) begin
            for (int i = 0; i < 4; i++) m_active[i] <= m_shadow[i];
            m_pending <= 1'b0;
         end else if (commit && !m_pending) begin
            m_pending <= 1'b1;
         end
      end
   end

   task automatic check_output(input string name, input logic [6:0] actual,
                               input logic [6:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (check_on) begin
         check_output("an_model",    {3'b0, an},         {3'b0, m_an});
         check_output("seg_model",   segment,             m_seg);
         check_output("ready_model", {6'b0, wr_ready},    {6'b0, !m_pending});
         check_output("busy_model",  {6'b0, commit_busy}, {6'b0, m_pending});
      end
   end

   task automatic apply_stimulus(input logic v, input logic [1:0] a,
                                 input logic [4:0] d, input logic c);
      wr_valid = v;
      wr_addr  = a;
      wr_data  = d;
      commit   = c;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(1'b0, 2'd0, 5'd0, 1'b0);
   endtask

   task automatic wait_commit_done(output int n);
      n = 0;
      while (commit_busy && n < 200) begin
         idle(1);
         n++;
      end
      if (commit_busy) check_output("commit_timeout", 7'd1, 7'd0);
   endtask

   int n;

   initial begin
      rst = 1'b1;
      wr_valid = 1'b0; wr_addr = 2'd0; wr_data = 5'd0; commit = 1'b0;
      @(negedge clk);
      check_on = 1'b1;
      idle(2);
      check_output("reset_an",  {3'b0, an}, 7'b0001111);
      check_output("reset_seg", segment,    7'b1111111);
      rst = 1'b0;

      // Idle after reset: everything stays dark
      idle(64);
      check_output("idle_an",    {3'b0, an},         7'b0001111);
      check_output("idle_seg",   segment,             7'b1111111);
      check_output("idle_ready", {6'b0, wr_ready},    7'd1);
      check_output("idle_busy",  {6'b0, commit_busy}, 7'd0);

      // Write 1,2,3,4 and commit
      for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 2'(i), 5'(i + 1), 1'b0);
      apply_stimulus(1'b0, 2'd0, 5'd0, 1'b1);
      check_output("busy_after_commit", {6'b0, commit_busy}, 7'd1);
      wait_commit_done(n);
      idle(3);
      check_output("d0_an",  {3'b0, an}, 7'b0001110);
      check_output("d0_seg", segment,    7'b1111001);
      idle(8);
      check_output("d1_an",  {3'b0, an}, 7'b0001101);
      check_output("d1_seg", segment,    7'b0100100);
      idle(8);
      check_output("d2_an",  {3'b0, an}, 7'b0001011);
      check_output("d2_seg", segment,    7'b0110000);
      idle(8);
      check_output("d3_an",  {3'b0, an}, 7'b0000111);
      check_output("d3_seg", segment,    7'b0011001);

      // Write held off while a commit is pending
      apply_stimulus(1'b0, 2'd0, 5'd0, 1'b1);
      wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 5'h05; commit = 1'b0;
      check_output("ready_low_pending", {6'b0, wr_ready}, 7'd0);
      n = 0;
      while (!wr_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!wr_ready) check_output("ready_timeout", 7'd1, 7'd0);
      apply_stimulus(1'b1, 2'd0, 5'h05, 1'b0);
      apply_stimulus(1'b0, 2'd0, 5'd0, 1'b1);
      wait_commit_done(n);
      idle(3);
      check_output("held_write_seg", segment, 7'b0010010);

      // Commit issued in the boundary cycle waits one full frame
      apply_stimulus(1'b1, 2'd1, 5'h07, 1'b0);
      n = 0;
      while ((m_pos % FRAME) != FRAME - 1 && n < 64) begin
         idle(1);
         n++;
      end
      apply_stimulus(1'b0, 2'd0, 5'd0, 1'b1);
      wait_commit_done(n);
      check_output("boundary_commit_wait", 7'(n), 7'd32);
      idle(11);
      check_output("d1_seven_seg", segment, 7'b1111000);

      // Blank digit 2
      apply_stimulus(1'b1, 2'd2, 5'h12, 1'b1);
      wait_commit_done(n);
      idle(19);
      check_output("blank_d2_an", {3'b0, an}, 7'b0001111);
      idle(8);
      check_output("after_blank_d3_an", {3'b0, an}, 7'b0000111);

      // Reset mid-frame with a commit pending
      apply_stimulus(1'b1, 2'd3, 5'h0A, 1'b1);
      idle(5);
      rst = 1'b1;
      @(negedge clk);
      check_output("rst_an",    {3'b0, an},         7'b0001111);
      check_output("rst_seg",   segment,             7'b1111111);
      check_output("rst_busy",  {6'b0, commit_busy}, 7'd0);
      check_output("rst_ready", {6'b0, wr_ready},    7'd1);
      rst = 1'b0;
      idle(40);
      check_output("post_rst_an", {3'b0, an}, 7'b0001111);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
